mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified instruction/data memory between the fetch port (IF) and the

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_prio_sel.sv | 38 +++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    localparam logic [3:0] BE_ALL = 4'hF;

    // Bit positions inside the selector's grant vector
    localparam int unsigned GNT_IF = 0;
    localparam int unsigned GNT_D  = 1;

endpackage

// File: rtl/arb_prio_sel.sv
// Two-way request selector for the memory port arbiter.
// Define MEM_ARB_RR_EN for round-robin; otherwise D has fixed priority over IF.
module arb_prio_sel
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
`ifdef MEM_ARB_RR_EN
    input  arb_owner_t last_owner,
`endif
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
`ifdef MEM_ARB_RR_EN
        // On a tie the port that did not win last time goes first
        if (if_req && d_req) begin
            if (last_owner == OWN_D) begin
                gnt[GNT_IF] = 1'b1;
            end else begin
                gnt[GNT_D] = 1'b1;
            end
        end else if (d_req) begin
            gnt[GNT_D] = 1'b1;
        end else if (if_req) begin
            gnt[GNT_IF] = 1'b1;
        end
`else
        if (d_req) begin
            gnt[GNT_D] = 1'b1;
        end else if (if_req) begin
            gnt[GNT_IF] = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (IF) and load/store (D) ports.
// Arbitration policy selected by MEM_ARB_RR_EN (round-robin) or fixed D-over-IF when undefined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned     CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t       state;
    arb_owner_t       owner;
    logic [CNT_W-1:0] cnt;
    logic             is_store;
    logic [1:0]       sel;
    logic             done_c;

    arb_prio_sel u_prio_sel (
        .if_req     (if_req),
        .d_req      (d_req),
`ifdef MEM_ARB_RR_EN
        .last_owner (owner),
`endif
        .gnt        (sel)
    );

    // Grants are only offered while no transaction is in flight
    assign if_gnt = (state == IDLE) && sel[GNT_IF];
    assign d_gnt  = (state == IDLE) && sel[GNT_D];

    // Cycle in which mem_rdata is valid for the current transaction
    assign done_c = ((state == ACCESS) && (MEM_LATENCY == 1)) ||
                    ((state == WAIT) && (cnt == CNT_ONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_D;
            cnt       <= '0;
            is_store  <= 1'b0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_gnt || d_gnt) begin
                        state     <= ACCESS;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        owner     <= d_gnt ? OWN_D : OWN_IF;
                        is_store  <= d_gnt && d_we;
                        mem_we    <= d_gnt && d_we;
                        mem_addr  <= d_gnt ? d_addr : if_addr;
                        mem_wdata <= d_gnt ? d_wdata : '0;
                        mem_be    <= (d_gnt && d_we) ? d_be : BE_ALL;
                    end
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (!done_c) begin
                        cnt   <= CNT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!done_c) begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Capture the read data and pulse the owner's rvalid
            if (done_c) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
                if (owner == OWN_D) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= is_store ? '0 : mem_rdata;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: latency-2 instance with mixed traffic and a latency-1 instance
// under continuous fetch, both checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        if_req1, if_gnt1, if_rvalid1;
    logic [31:0] if_addr1, if_rdata1;
    logic        d_req1, d_we1, d_gnt1, d_rvalid1;
    logic [31:0] d_addr1, d_wdata1, d_rdata1;
    logic [3:0]  d_be1;
    logic        mem_en1, mem_we1, busy1;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;
    logic [3:0]  mem_be1;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1), .d_be(d_be1),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_be(mem_be1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h00500093;
    endfunction

    // Memory macro: latency-2 registered read with byte-enabled writes
    logic [31:0] macro_mem [logic [31:0]];
    always @(posedge clk) begin : macro_blk
        logic [31:0] cur;
        if (mem_en) begin
            cur = macro_mem.exists(mem_addr) ? macro_mem[mem_addr] : init_val(mem_addr);
            mem_rdata <= cur;
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
                macro_mem[mem_addr] = cur;
            end
        end else begin
            mem_rdata <= 32'hBAD0_0BAD;
        end
    end

    // Latency-1 macro: combinational read-only
    assign mem_rdata1 = mem_en1 ? init_val(mem_addr1) : 32'hBAD1_1BAD;

    // Reference memory kept by the bench
    logic [31:0] ref_mem [logic [31:0]];
    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction
    function automatic void ref_write(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        logic [31:0] v;
        v = ref_read(a);
        for (int b = 0; b < 4; b++)
            if (be[b]) v[8*b +: 8] = w[8*b +: 8];
        ref_mem[a] = v;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Transaction-level model state
    int          free_cyc, acc_cyc, rsp_cyc;
    bit          rsp_d, last_d, g_if, g_d;
    logic        acc_we;
    logic [31:0] acc_addr, acc_wdata, rsp_data, exp_if_rdata, exp_d_rdata;
    logic [3:0]  acc_be;
    int          free1, acc1_cyc, rsp1_cyc;
    bit          g1;
    logic [31:0] acc1_addr, rsp1_data, exp_if_rdata1;

    // Stimulus state
    bit          if_pend, d_pend, if1_on, rnd_on, hold_both, rec_on;
    logic [31:0] if_cmd_addr, d_cmd_addr, d_cmd_wdata, if1_cmd_addr;
    logic        d_cmd_we;
    logic [3:0]  d_cmd_be;
    bit          gseq[$];

    function automatic logic [31:0] rnd_addr();
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction
    task automatic new_if();
        if_pend = 1'b1; if_cmd_addr = rnd_addr();
    endtask
    task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        d_pend = 1'b1; d_cmd_we = we; d_cmd_addr = a; d_cmd_wdata = w; d_cmd_be = be;
    endtask
    task automatic new_d();
        set_d(1'($urandom_range(0, 1)), rnd_addr(), $urandom, 4'($urandom_range(1, 15)));
    endtask

    task automatic model_reset();
        free_cyc = 0; acc_cyc = -1; rsp_cyc = -1; last_d = 1'b1;
        exp_if_rdata = '0; exp_d_rdata = '0;
        free1 = 0; acc1_cyc = -1; rsp1_cyc = -1; exp_if_rdata1 = '0;
    endtask

    task automatic model_check();
        bit busy_e, busy1_e;
        busy_e = (cyc < free_cyc);
        g_if = 1'b0; g_d = 1'b0;
        if (!busy_e && (if_req || d_req)) begin
            g_d  = (if_req && d_req) ? (RR ? !last_d : 1'b1) : d_req;
            g_if = !g_d;
        end
        chk("if_gnt", if_gnt, g_if);
        chk("d_gnt", d_gnt, g_d);
        chk("busy", busy, busy_e);
        chk("mem_en", mem_en, cyc == acc_cyc);
        if (cyc == acc_cyc) begin
            chk("mem_addr", mem_addr, acc_addr);
            chk("mem_we", mem_we, acc_we);
            chk("mem_be", mem_be, acc_be);
            if (acc_we) chk("mem_wdata", mem_wdata, acc_wdata);
        end
        chk("if_rvalid", if_rvalid, (cyc == rsp_cyc) && !rsp_d);
        chk("d_rvalid", d_rvalid, (cyc == rsp_cyc) && rsp_d);
        if (cyc == rsp_cyc) begin
            if (rsp_d) exp_d_rdata = rsp_data;
            else       exp_if_rdata = rsp_data;
        end
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        if (g_if || g_d) begin
            acc_cyc   = cyc + 1;
            rsp_cyc   = cyc + 1 + LAT;
            free_cyc  = rsp_cyc;
            rsp_d     = g_d;
            last_d    = g_d;
            acc_addr  = g_d ? d_addr : if_addr;
            acc_we    = g_d && d_we;
            acc_be    = acc_we ? d_be : 4'hF;
            acc_wdata = d_wdata;
            rsp_data  = acc_we ? 32'h0 : ref_read(acc_addr);
            if (acc_we) ref_write(acc_addr, d_wdata, d_be);
        end

        // Latency-1 instance, fetch only
        busy1_e = (cyc < free1);
        g1 = !busy1_e && if_req1;
        chk("if_gnt1", if_gnt1, g1);
        chk("d_gnt1", d_gnt1, 1'b0);
        chk("busy1", busy1, busy1_e);
        chk("mem_en1", mem_en1, cyc == acc1_cyc);
        if (cyc == acc1_cyc) begin
            chk("mem_addr1", mem_addr1, acc1_addr);
            chk("mem_we1", mem_we1, 1'b0);
            chk("mem_be1", mem_be1, 4'hF);
        end
        chk("if_rvalid1", if_rvalid1, cyc == rsp1_cyc);
        chk("d_rvalid1", d_rvalid1, 1'b0);
        if (cyc == rsp1_cyc) exp_if_rdata1 = rsp1_data;
        chk("if_rdata1", if_rdata1, exp_if_rdata1);
        chk("d_rdata1", d_rdata1, 32'h0);
        if (g1) begin
            acc1_cyc  = cyc + 1;
            rsp1_cyc  = cyc + 2;
            free1     = rsp1_cyc;
            acc1_addr = if_addr1;
            rsp1_data = init_val(if_addr1);
        end

        if (reset) model_reset();
    endtask

    // One clock cycle: drive, check, update stimulus, advance to the next edge
    task automatic step();
        if (rnd_on) begin
            if (!if_pend && $urandom_range(0, 2) == 0) new_if();
            if (!d_pend && $urandom_range(0, 2) == 0) new_d();
        end
        if_req  = if_pend; if_addr = if_cmd_addr;
        d_req   = d_pend;  d_we = d_cmd_we; d_addr = d_cmd_addr; d_wdata = d_cmd_wdata; d_be = d_cmd_be;
        if_req1 = if1_on;  if_addr1 = if1_cmd_addr;
        #1;
        if (rec_on && (if_gnt || d_gnt)) gseq.push_back(d_gnt);
        model_check();
        if (g_if) begin if (hold_both) new_if(); else if_pend = 1'b0; end
        if (g_d)  begin if (hold_both) new_d();  else d_pend = 1'b0; end
        if (g1) if1_cmd_addr = rnd_addr();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin : main
        logic [31:0] t;
        bit exp_d;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        if_req1 = 0; if_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0; d_be1 = 0;
        if_pend = 0; d_pend = 0; if1_on = 0; rnd_on = 0; hold_both = 0; rec_on = 0;
        if_cmd_addr = 0; d_cmd_addr = 0; d_cmd_wdata = 0; d_cmd_we = 0; d_cmd_be = 0; if1_cmd_addr = 0;
        model_reset();
        @(posedge clk);
        #1;
        repeat (2) step();
        reset = 1'b0;
        if1_on = 1'b1;

        // Single fetch from 0x0
        if_pend = 1'b1; if_cmd_addr = 32'h0;
        repeat (4) step();
        chk("t1_if_rdata", if_rdata, 32'h00500093);

        // Load and fetch arriving together
        set_d(1'b0, 32'h100, 32'h0, 4'h0);
        if_pend = 1'b1; if_cmd_addr = 32'h4;
        repeat (8) step();

        // Partial store, then read it back
        set_d(1'b1, 32'h200, 32'hDEADBEEF, 4'h3);
        repeat (4) step();
        chk("t3_d_rdata_store", d_rdata, 32'h0);
        set_d(1'b0, 32'h200, 32'h0, 4'h0);
        repeat (4) step();
        t = init_val(32'h200);
        chk("t3_readback", d_rdata, {t[31:16], 16'hBEEF});

        // Both ports held across four transactions
        new_if(); new_d();
        hold_both = 1'b1; rec_on = 1'b1;
        repeat (12) step();
        hold_both = 1'b0; rec_on = 1'b0;
        chk("t4_grants", 32'(gseq.size()), 32'd4);
        for (int i = 0; i < 4 && i < gseq.size(); i++) begin
            exp_d = RR ? (i % 2 == 1) : 1'b1;
            chk($sformatf("t4_grant%0d_is_d", i), gseq[i], exp_d);
        end
        repeat (8) step();

        // Reset while a load sits in WAIT
        set_d(1'b0, 32'h300, 32'h0, 4'h0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (5) step();

        // Random mixed traffic
        rnd_on = 1'b1;
        repeat (400) step();
        rnd_on = 1'b0;
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
